serial_rx_shift_ctrl: RTL

- Sequencer for the 8-bit serial-in/parallel-out shift register (enable-capable variant, shifts only when `shift_en`=1).
- Watches the serial line for a start bit and gates the shifter for exactly WIDTH data bits.
- Checks the stop bit, then presents the assembled word through a valid/ready handshake.
- Sits between the serial line and any byte-wide consumer; the shifter stays a pure datapath.

---
 rtl/serial_rx_shift_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_rx_shift_ctrl.sv
// Serial receive sequencer: finds the start bit, gates an external SIPO shifter for WIDTH bits,
// checks the stop bit and offers the word over valid/ready. Optional parity check: SERIAL_RX_PARITY_EN.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle-high, waiting for a start bit (serial_in = 0)
// SHIFT  | shifter enabled, one data bit per cycle, WIDTH cycles
// PARITY | (SERIAL_RX_PARITY_EN only) even-parity bit on the line
// STOP   | stop bit on the line; good stop captures par_in
// BREAK  | stop bit was low; hold off until the line returns high
module serial_rx_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    output logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        STOP   = 3'd2,
        BREAK  = 3'd3
`ifdef SERIAL_RX_PARITY_EN
        , PARITY = 3'd4
`endif
    } stateT;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] bitCnt;
    logic [CNT_W-1:0] bitCntNext;
    logic             frameOk;
    logic             frameBad;

`ifdef SERIAL_RX_PARITY_EN
    logic parityAcc;
    logic parityAccNext;
    logic parityErr;
    logic parityErrNext;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            bitCnt <= '0;
`ifdef SERIAL_RX_PARITY_EN
            parityAcc <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            state  <= stateNext;
            bitCnt <= bitCntNext;
`ifdef SERIAL_RX_PARITY_EN
            parityAcc <= parityAccNext;
            parityErr <= parityErrNext;
`endif
        end
    end

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        frameOk    = 1'b0;
        frameBad   = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        parityAccNext = parityAcc;
        parityErrNext = parityErr;
`endif
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!serial_in) begin
                    stateNext  = SHIFT;
                    bitCntNext = '0;
`ifdef SERIAL_RX_PARITY_EN
                    parityAccNext = 1'b0;
`endif
                end
            end
            SHIFT: begin
                shift_en   = 1'b1;
                bitCntNext = bitCnt + CNT_W'(1);
`ifdef SERIAL_RX_PARITY_EN
                parityAccNext = parityAcc ^ serial_in;
`endif
                if (bitCnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                    stateNext = PARITY;
`else
                    stateNext = STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                // Even parity: data bits plus parity bit must XOR to zero.
                parityErrNext = parityAcc ^ serial_in;
                stateNext     = STOP;
            end
`endif
            STOP: begin
                if (serial_in) begin
                    stateNext = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                    frameOk  = !parityErr;
                    frameBad = parityErr;
`else
                    frameOk  = 1'b1;
`endif
                end else begin
                    // Low stop bit: wait in BREAK so a held-low line is not taken as a new start.
                    stateNext = BREAK;
                    frameBad  = 1'b1;
                end
            end
            BREAK: begin
                if (serial_in) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output register: a consumer read in the capture cycle frees the slot for the new word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frameBad;
            overrun   <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            if (frameOk) begin
                if (!data_valid || data_ready) begin
                    data_out   <= par_in;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
